alu_result_packer: RTL and testbench

Downstream stage of the ALU. Captures each valid ALU result and splits it into bytes, least-significant byte first. It presents the bytes on a valid/ready byte stream to the TX FIFO / UART transmit path. A one-entry pending slot absorbs a result that arrives while a transfer is in progress; any further overflow is dropped and flagged.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_result_packer_if.sv | 27 ++
 rtl/alu_result_packer.sv | 126 ++++++++++++
 tb/tb_alu_result_packer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, result-packer FSM states and
// the default result/byte geometry used by the packer and its interface.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLL  = 3'd5,
    ALU_SRL  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CHK  = 2'd2
  } pkr_state_e;

  localparam int DEF_OUT_WIDTH  = 16;
  localparam int DEF_BYTE_WIDTH = 8;
  localparam int NUM_BYTES      = DEF_OUT_WIDTH / DEF_BYTE_WIDTH;
  localparam int IDX_WIDTH      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

endpackage

// File: rtl/alu_result_packer_if.sv
// Result input and byte-stream output of the ALU result packer.
// slave = packer side, master = ALU / TX-path side.
interface alu_result_packer_if
  import alu_pkg::*;
#(
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
);
  logic [OUT_WIDTH-1:0]  ALU_OUT;
  logic                  OUT_VALID;
  logic [BYTE_WIDTH-1:0] TX_DATA;
  logic                  TX_VALID;
  logic                  TX_READY;
  logic                  BUSY;
  logic                  OVERRUN;
  logic                  CLR_OVERRUN;

  modport slave (
    input  ALU_OUT, OUT_VALID, TX_READY, CLR_OVERRUN,
    output TX_DATA, TX_VALID, BUSY, OVERRUN
  );

  modport master (
    output ALU_OUT, OUT_VALID, TX_READY, CLR_OVERRUN,
    input  TX_DATA, TX_VALID, BUSY, OVERRUN
  );
endinterface

// File: rtl/alu_result_packer.sv
// Splits each ALU result into an LSB-first valid/ready byte stream with a
// one-entry pending slot. Define ALU_RESULT_PACKER_CHECKSUM_EN to append an XOR byte.
module alu_result_packer
  import alu_pkg::*;
#(
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
) (
  input logic          CLK,
  input logic          RST,
  alu_result_packer_if.slave bus
);

  localparam int N_BYTES = OUT_WIDTH / BYTE_WIDTH;
  localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  if (OUT_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("OUT_WIDTH must be a multiple of BYTE_WIDTH");
  end

  typedef logic [N_BYTES-1:0][BYTE_WIDTH-1:0] word_t;

  pkr_state_e            state, state_nxt;
  word_t                 active, pend;
  logic                  pend_v, overrun;
  logic [IDX_W-1:0]      idx;
  logic [BYTE_WIDTH-1:0] tx_data;
  logic                  tx_valid, xfer, last_byte, eow, next_word, drop;

  assign tx_valid  = (state != IDLE);
  assign xfer      = tx_valid && bus.TX_READY;
  assign last_byte = (state == SEND) && (idx == IDX_W'(N_BYTES - 1));
  assign next_word = pend_v || bus.OUT_VALID;
`ifdef ALU_RESULT_PACKER_CHECKSUM_EN
  assign eow       = xfer && (state == CHK);
`else
  assign eow       = xfer && last_byte;
`endif
  // A result arriving mid-word with the pending slot full is lost.
  assign drop      = bus.OUT_VALID && tx_valid && !eow && pend_v;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.OUT_VALID) state_nxt = SEND;
      SEND: if (xfer && last_byte) begin
`ifdef ALU_RESULT_PACKER_CHECKSUM_EN
        state_nxt = CHK;
`else
        state_nxt = next_word ? SEND : IDLE;
`endif
      end
`ifdef ALU_RESULT_PACKER_CHECKSUM_EN
      CHK:  if (xfer) state_nxt = next_word ? SEND : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_RESULT_PACKER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] chk;
  always_comb begin
    chk = '0;
    for (int i = 0; i < N_BYTES; i++) chk = chk ^ active[i];
  end
`endif

  always_comb begin
    tx_data = '0;
    if (state == SEND) tx_data = active[idx];
`ifdef ALU_RESULT_PACKER_CHECKSUM_EN
    else if (state == CHK) tx_data = chk;
`endif
  end

  assign bus.TX_DATA  = tx_data;
  assign bus.TX_VALID = tx_valid;
  assign bus.BUSY     = pend_v;
  assign bus.OVERRUN  = overrun;

  // NOTE: the data registers are cleared on reset too, so nothing from a
  // discarded word can leak out after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      active  <= '0;
      pend    <= '0;
      pend_v  <= 1'b0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (bus.OUT_VALID) begin
          active <= bus.ALU_OUT;
          idx    <= '0;
        end
      end else if (eow) begin
        idx <= '0;
        if (pend_v) begin
          active <= pend;
          if (bus.OUT_VALID) pend <= bus.ALU_OUT;
          else               pend_v <= 1'b0;
        end else if (bus.OUT_VALID) begin
          active <= bus.ALU_OUT;
        end
      end else begin
        if (xfer && (state == SEND) && !last_byte) idx <= idx + 1'b1;
        if (bus.OUT_VALID && !pend_v) begin
          pend   <= bus.ALU_OUT;
          pend_v <= 1'b1;
        end
      end

      if (drop)                 overrun <= 1'b1;
      else if (bus.CLR_OVERRUN) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_packer.sv
// Bench for alu_result_packer: hand-computed vector table, then random
// traffic against a word-queue reference model.
module tb_alu_result_packer;
  import alu_pkg::*;

  localparam int OW = DEF_OUT_WIDTH;
  localparam int BW = DEF_BYTE_WIDTH;
  localparam int NB = OW / BW;
`ifdef ALU_RESULT_PACKER_CHECKSUM_EN
  localparam int BPW = NB + 1;
`else
  localparam int BPW = NB;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;

  alu_result_packer_if #(.OUT_WIDTH(OW), .BYTE_WIDTH(BW)) bus ();

  alu_result_packer #(.OUT_WIDTH(OW), .BYTE_WIDTH(BW)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted words (head = word on the wire),
  // at most two in flight, plus the byte offset within the head word.
  logic [OW-1:0] mq[$];
  int            boff;
  bit            movr;

  function automatic logic [BW-1:0] byte_of(input logic [OW-1:0] w, input int k);
    logic [BW-1:0] x;
    if (k < NB) return BW'(w >> (BW * k));
    x = '0;
    for (int i = 0; i < NB; i++) x = x ^ BW'(w >> (BW * i));
    return x;
  endfunction

  task automatic model_step(input bit r, input logic [OW-1:0] a, input bit v,
                            input bit rd, input bit c);
    bit dropped;
    dropped = 1'b0;
    if (r) begin
      mq.delete();
      boff = 0;
      movr = 1'b0;
      return;
    end
    if (mq.size() > 0 && rd) begin
      if (boff == BPW - 1) begin
        void'(mq.pop_front());
        boff = 0;
      end else begin
        boff++;
      end
    end
    if (v) begin
      if (mq.size() < 2) mq.push_back(a);
      else               dropped = 1'b1;
    end
    if (dropped) movr = 1'b1;
    else if (c)  movr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic          ev;
    logic [BW-1:0] ed;
    ev = (mq.size() > 0);
    ed = ev ? byte_of(mq[0], boff) : '0;
    check({tag, ".tx_valid"}, bus.TX_VALID, ev);
    check({tag, ".tx_data"},  bus.TX_DATA,  ed);
    check({tag, ".busy"},     bus.BUSY,     mq.size() == 2);
    check({tag, ".overrun"},  bus.OVERRUN,  movr);
  endtask

  // Drive one cycle's inputs, advance the model, and wait past the edge.
  task automatic apply(input bit r, input logic [OW-1:0] a, input bit v,
                       input bit rd, input bit c);
    RST             = r;
    bus.ALU_OUT     = a;
    bus.OUT_VALID   = v;
    bus.TX_READY    = rd;
    bus.CLR_OVERRUN = c;
    model_step(r, a, v, rd, c);
    @(negedge CLK);
  endtask

  typedef struct {
    bit            r;
    logic [OW-1:0] a;
    bit            v, rd, c;
    bit            ev;
    logic [BW-1:0] ed;
    bit            eb, eo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input logic [OW-1:0] a, input bit v, input bit rd,
                              input bit c, input bit ev, input logic [BW-1:0] ed,
                              input bit eb, input bit eo);
    vec_t t;
    t.r = r; t.a = a; t.v = v; t.rd = rd; t.c = c;
    t.ev = ev; t.ed = ed; t.eb = eb; t.eo = eo;
    tbl.push_back(t);
  endfunction

  initial begin
    bus.ALU_OUT = '0; bus.OUT_VALID = 1'b0; bus.TX_READY = 1'b0; bus.CLR_OVERRUN = 1'b0;
    mq.delete(); boff = 0; movr = 1'b0;
    @(negedge CLK);

    apply(1, 16'h0, 0, 0, 0);
    check("reset.tx_valid", bus.TX_VALID, 0);
    check("reset.tx_data",  bus.TX_DATA,  0);
    check("reset.busy",     bus.BUSY,     0);
    check("reset.overrun",  bus.OVERRUN,  0);

`ifndef ALU_RESULT_PACKER_CHECKSUM_EN
    //   r  a        v  rd c   ev ed     eb eo
    add(0, 16'h1234, 1, 1, 0,  1, 8'h34, 0, 0);   // single result
    add(0, 16'h0000, 0, 1, 0,  1, 8'h12, 0, 0);
    add(0, 16'h0000, 0, 1, 0,  0, 8'h00, 0, 0);
    add(0, 16'hABCD, 1, 0, 0,  1, 8'hCD, 0, 0);   // stall five cycles
    for (int i = 0; i < 5; i++) add(0, 16'h0, 0, 0, 0, 1, 8'hCD, 0, 0);
    add(0, 16'h0000, 0, 1, 0,  1, 8'hAB, 0, 0);
    add(0, 16'h0000, 0, 1, 0,  0, 8'h00, 0, 0);
    add(0, 16'h0102, 1, 1, 0,  1, 8'h02, 0, 0);   // back-to-back
    add(0, 16'h0304, 1, 1, 0,  1, 8'h01, 1, 0);
    add(0, 16'h0000, 0, 1, 0,  1, 8'h04, 0, 0);
    add(0, 16'h0000, 0, 1, 0,  1, 8'h03, 0, 0);
    add(0, 16'h0000, 0, 1, 0,  0, 8'h00, 0, 0);
    add(0, 16'h1111, 1, 0, 0,  1, 8'h11, 0, 0);   // overrun
    add(0, 16'h2222, 1, 0, 0,  1, 8'h11, 1, 0);
    add(0, 16'h3333, 1, 0, 0,  1, 8'h11, 1, 1);
    add(0, 16'h0000, 0, 1, 0,  1, 8'h11, 1, 1);
    add(0, 16'h0000, 0, 1, 0,  1, 8'h22, 0, 1);
    add(0, 16'h0000, 0, 1, 0,  1, 8'h22, 0, 1);
    add(0, 16'h0000, 0, 1, 0,  0, 8'h00, 0, 1);
    add(0, 16'h0000, 0, 0, 1,  0, 8'h00, 0, 0);
    add(0, 16'hAAAA, 1, 0, 0,  1, 8'hAA, 0, 0);   // clear coincides with drop
    add(0, 16'hBBBB, 1, 0, 0,  1, 8'hAA, 1, 0);
    add(0, 16'hCCCC, 1, 0, 1,  1, 8'hAA, 1, 1);
    add(0, 16'h0000, 0, 0, 0,  1, 8'hAA, 1, 1);
    add(1, 16'h0000, 0, 0, 0,  0, 8'h00, 0, 0);
    add(0, 16'h1234, 1, 1, 0,  1, 8'h34, 0, 0);   // reset mid-word
    add(0, 16'h0000, 0, 1, 0,  1, 8'h12, 0, 0);
    add(1, 16'h0000, 0, 1, 0,  0, 8'h00, 0, 0);
    add(0, 16'h5678, 1, 1, 0,  1, 8'h78, 0, 0);
    add(0, 16'h0000, 0, 1, 0,  1, 8'h56, 0, 0);
    add(0, 16'h0000, 0, 1, 0,  0, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].a, tbl[i].v, tbl[i].rd, tbl[i].c);
      check($sformatf("vec%0d.tx_valid", i), bus.TX_VALID, tbl[i].ev);
      check($sformatf("vec%0d.tx_data", i),  bus.TX_DATA,  tbl[i].ed);
      check($sformatf("vec%0d.busy", i),     bus.BUSY,     tbl[i].eb);
      check($sformatf("vec%0d.overrun", i),  bus.OVERRUN,  tbl[i].eo);
    end
`else
    apply(0, 16'h1234, 1, 1, 0);
    check("chk.byte0", bus.TX_DATA, 8'h34);
    apply(0, 16'h0000, 0, 1, 0);
    check("chk.byte1", bus.TX_DATA, 8'h12);
    apply(0, 16'h0000, 0, 1, 0);
    check("chk.xor", bus.TX_DATA, 8'h26);
    check("chk.valid", bus.TX_VALID, 1);
    apply(0, 16'h0000, 0, 1, 0);
    check("chk.idle", bus.TX_VALID, 0);
`endif

    apply(1, 16'h0, 0, 0, 0);
    check_model("rst");
    for (int n = 0; n < 3000; n++) begin
      apply($urandom_range(199) == 0,
            OW'($urandom),
            $urandom_range(9) < 4,
            $urandom_range(9) < 6,
            $urandom_range(19) == 0);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
